complex_vector_unpacker: RTL and testbench
==========================================

Name: complex_vector_unpacker

Overview:
- Sits directly downstream of the complex decoder. Captures each assembled 2*no_of_units-element word when the decoder pulses its ready strobe.
- Buffers captured words in a small FIFO, then serializes each one into per-element complex samples (real, imag, index).
- Output uses a valid/ready handshake for the complex arithmetic units.
- Lower half of each captured word is the real vector (first decoder word); upper half is the imaginary vector.

Parameters:
no_of_units, 4, elements per vector half
element_width, 64, bits per element
fifo_depth, 4, captured words buffered; power of 2, >=2

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in  in  2*element_width*no_of_units  assembled word from decoder
in_valid  in  1  one-cycle capture strobe (decoder outsider_read_now)
out_real  out  element_width  real part of current element
out_imag  out  element_width  imaginary part of current element
out_index  out  max(1,clog2(no_of_units))  element index within vector
out_valid  out  1  current element valid
out_ready  in  1  consumer accepts element
out_last  out  1  current element is index no_of_units-1
fifo_count  out  clog2(fifo_depth)+1  words held, 0..fifo_depth
overflow  out  1  sticky: a strobe was dropped

Behaviour:
- Reset (async assert, sync release): write pointer, read pointer, fifo_count, element index and overflow are all 0. out_valid=0 and out_last=0. FIFO memory is not cleared.
- Element mapping for head word H and index k:
  - out_real = H[k*element_width +: element_width].
  - out_imag = H[(no_of_units+k)*element_width +: element_width].
- Push: on a clk edge with in_valid=1, the word is written if fifo_count<fifo_depth, or if a pop occurs in the same cycle. Otherwise the word is dropped and overflow is set to 1. overflow clears only on reset.
- Output datapath: out_valid = (fifo_count!=0), derived from registered state only; there is no combinational path from in or in_valid.
  - out_real, out_imag and out_index are driven from the head entry and the index register.
  - out_last = out_valid && index==no_of_units-1.
- Latency: a word pushed at edge N is first visible with out_valid=1 after edge N, when the FIFO was empty. Four elements then need at least 4 accepting cycles.
- Handshake: an element transfers when out_valid && out_ready. Otherwise out_real, out_imag, out_index and out_last hold stable.
  - If index<no_of_units-1, index increments.
  - If index==no_of_units-1, index goes to 0, the head word pops and the read pointer advances.
- Pointers wrap modulo fifo_depth.
- Simultaneous push and pop: fifo_count is unchanged and both pointers advance. The full FIFO accepts the push with no overflow.
- Push only: count+1. Pop only: count-1.
- in_valid with out_ready=0 for many cycles: the FIFO fills to fifo_depth; later strobes drop and set overflow. Stored words are never corrupted.
- Reset mid-vector: all buffered words are discarded and index returns to 0. The next pushed word starts at index 0.
- out_ready while out_valid=0 is ignored.

Test Plan:
- Single vector: reset, then push in with real elements 0x10,0x11,0x12,0x13 and imag 0x20..0x23, out_ready=1 -> next four cycles output (0x10,0x20,0)...(0x13,0x23,3). out_last only on the 4th. fifo_count goes 1 then 0.
- Backpressure: push one word with out_ready=0 for 5 cycles -> out_valid=1, index 0 held stable. Raise out_ready -> elements 0..3 in order with no skips.
- Fill and overflow: out_ready=0, 5 strobes of distinct words A..E -> fifo_count=4, overflow=1. Drain -> A,B,C,D delivered in order; E absent.
- Full with simultaneous push/pop: FIFO holds 4 words, index=3, out_ready=1, in_valid=1 with word F -> pop of head and push of F in the same cycle. fifo_count stays 4, overflow stays 0, F emerges last.
- Wrap-around: stream 10 words with continuous out_ready=1, one strobe every 4 cycles -> all 40 elements delivered in order. Pointers wrap and fifo_count never exceeds 2.
- Reset mid-operation: assert rst_n=0 during index=2 of a word with 2 words buffered -> out_valid=0, fifo_count=0, overflow=0 immediately. After release, a new word outputs from index 0.

Source files
------------

// File: rtl/complex_vector_unpacker.sv
// complex_vector_unpacker
// Captures assembled real/imag vector words from the complex decoder into a
// small FIFO and replays each word as a stream of per-element complex samples
// (real, imag, index) over a valid/ready handshake.
//
// Word layout: the lower half of a captured word is the real vector and the
// upper half is the imaginary vector. Element k sits at slot k in each half.
//
// All outputs come from registered state (FIFO storage, pointers, count and
// the element index). Nothing from in/in_valid reaches the outputs in the
// same cycle.

module complex_vector_unpacker #(
  parameter int no_of_units   = 4,
  parameter int element_width = 64,
  parameter int fifo_depth    = 4,
  localparam int IDX_W  = (no_of_units > 1) ? $clog2(no_of_units) : 1,
  localparam int PTR_W  = $clog2(fifo_depth),
  localparam int CNT_W  = PTR_W + 1,
  localparam int WORD_W = 2 * element_width * no_of_units
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WORD_W-1:0]        in,
  input  logic                     in_valid,
  output logic [element_width-1:0] out_real,
  output logic [element_width-1:0] out_imag,
  output logic [IDX_W-1:0]         out_index,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [CNT_W-1:0]         fifo_count,
  output logic                     overflow
);

  // Typed constants so every comparison is width-matched.
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(no_of_units - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO  = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(fifo_depth);

  // FIFO storage. Left uninitialised on reset: the pointers and count
  // define which entries are live, so stale contents are never observed.
  logic [WORD_W-1:0] mem_q [fifo_depth];

  // Control state.
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic [IDX_W-1:0] idx_q,    idx_d;
  logic             ovf_q,    ovf_d;

  // Handshake and FIFO decisions for the current cycle.
  logic              valid_s;
  logic              fire_s;
  logic              last_s;
  logic              pop_s;
  logic              push_s;
  logic              drop_s;
  logic [WORD_W-1:0] head_s;

  // Decide transfer, pop, push and drop from registered state plus strobes.
  always_comb begin
    valid_s = (count_q != CNT_ZERO);
    last_s  = (idx_q == LAST_IDX);
    fire_s  = valid_s && out_ready;
    // The head word leaves only when its final element is accepted.
    pop_s   = fire_s && last_s;
    // A full FIFO still takes a strobe when the head pops in the same cycle,
    // since the freed slot is reused on the very same edge.
    push_s  = in_valid && ((count_q < CNT_DEPTH) || pop_s);
    drop_s  = in_valid && !push_s;
  end

  // Next-state for pointers, count, element index and the sticky overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    idx_d    = idx_q;
    ovf_d    = ovf_q;

    // Pointers wrap naturally because fifo_depth is a power of two.
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // Element index walks 0..no_of_units-1 per word, advancing on transfer.
    if (fire_s) begin
      if (last_s) begin
        idx_d = IDX_ZERO;
      end else begin
        idx_d = idx_q + IDX_ONE;
      end
    end else begin
      idx_d = idx_q;
    end

    // Occupancy: push and pop together leave the count unchanged.
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      2'b11:   count_d = count_q;
      default: count_d = count_q;
    endcase

    // Overflow is sticky until reset.
    if (drop_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Control registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      count_q  <= CNT_ZERO;
      idx_q    <= IDX_ZERO;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      ovf_q    <= ovf_d;
    end
  end

  // Write an accepted word into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= in;
    end
  end

  // Select the current element of the head word for presentation.
  always_comb begin
    head_s    = mem_q[rd_ptr_q];
    out_real  = head_s[idx_q * element_width +: element_width];
    out_imag  = head_s[(no_of_units + idx_q) * element_width +: element_width];
    out_index = idx_q;
    out_valid = valid_s;
    out_last  = valid_s && last_s;
    fifo_count = count_q;
    overflow   = ovf_q;
  end

endmodule

// File: tb/tb_complex_vector_unpacker.sv
// Self-checking bench for complex_vector_unpacker. Inputs change 1ns after
// the rising edge; outputs are sampled on the falling edge. A behavioural
// model (occupancy, element index, sticky overflow) plus an element queue
// predicts every output; each scenario task adds its own explicit checks.

module tb_complex_vector_unpacker;

  localparam int NU = 4;
  localparam int EW = 64;
  localparam int FD = 4;
  localparam int WW = 2 * EW * NU;

  typedef struct packed {
    logic [EW-1:0] re;
    logic [EW-1:0] im;
    logic [1:0]    idx;
  } elem_t;

  logic          clk;
  logic          rst_n;
  logic [WW-1:0] in_w;
  logic          in_valid;
  logic [EW-1:0] out_real;
  logic [EW-1:0] out_imag;
  logic [1:0]    out_index;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [2:0]    fifo_count;
  logic          overflow;

  elem_t sb[$];
  int    m_count;
  int    m_idx;
  bit    m_ovf;
  int    max_cnt;
  int    total;
  int    bad;

  complex_vector_unpacker #(
    .no_of_units(NU), .element_width(EW), .fifo_depth(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in(in_w), .in_valid(in_valid),
    .out_real(out_real), .out_imag(out_imag), .out_index(out_index),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WW-1:0] make_word(input logic [EW-1:0] rb, input logic [EW-1:0] ib);
    logic [WW-1:0] w;
    w = '0;
    for (int k = 0; k < NU; k++) begin
      w[k*EW +: EW]      = rb + EW'(k);
      w[(NU+k)*EW +: EW] = ib + EW'(k);
    end
    return w;
  endfunction

  function automatic logic [EW-1:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // One clock: compare outputs against the model at the falling edge,
  // advance the model for the coming rising edge, then step past it.
  task automatic tick();
    elem_t e;
    bit fire, pop, push;
    @(negedge clk);
    total++;
    if (out_valid !== (m_count != 0)) begin
      bad++; $display("FAIL out_valid: got %b want %b", out_valid, (m_count != 0));
    end
    total++;
    if (fifo_count !== 3'(m_count)) begin
      bad++; $display("FAIL fifo_count: got %0d want %0d", fifo_count, m_count);
    end
    total++;
    if (overflow !== m_ovf) begin
      bad++; $display("FAIL overflow: got %b want %b", overflow, m_ovf);
    end
    if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    if (m_count != 0) begin
      if (sb.size() == 0) begin
        total++; bad++; $display("FAIL scoreboard: empty while model holds %0d words", m_count);
      end else begin
        e = sb[0];
        total++;
        if (out_real !== e.re) begin
          bad++; $display("FAIL out_real: got %h want %h", out_real, e.re);
        end
        total++;
        if (out_imag !== e.im) begin
          bad++; $display("FAIL out_imag: got %h want %h", out_imag, e.im);
        end
        total++;
        if (out_index !== e.idx) begin
          bad++; $display("FAIL out_index: got %0d want %0d", out_index, e.idx);
        end
        total++;
        if (out_last !== (e.idx == 2'd3)) begin
          bad++; $display("FAIL out_last: got %b want %b", out_last, (e.idx == 2'd3));
        end
      end
    end
    fire = (m_count != 0) && (out_ready === 1'b1);
    pop  = fire && (m_idx == NU - 1);
    push = (in_valid === 1'b1) && ((m_count < FD) || pop);
    if ((in_valid === 1'b1) && !push) m_ovf = 1'b1;
    if (fire && sb.size() > 0) void'(sb.pop_front());
    if (fire) m_idx = (m_idx == NU - 1) ? 0 : m_idx + 1;
    if (push) begin
      for (int k = 0; k < NU; k++) begin
        e.re  = in_w[k*EW +: EW];
        e.im  = in_w[(NU+k)*EW +: EW];
        e.idx = 2'(k);
        sb.push_back(e);
      end
    end
    m_count = m_count + (push ? 1 : 0) - (pop ? 1 : 0);
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [WW-1:0] w);
    in_w     = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_w     = '0;
  endtask

  task automatic model_clear();
    sb.delete();
    m_count = 0;
    m_idx   = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain(input int limit);
    out_ready = 1'b1;
    for (int i = 0; i < limit && m_count != 0; i++) tick();
    total++;
    if (m_count != 0 || sb.size() != 0) begin
      bad++; $display("FAIL drain: %0d words / %0d elements left after %0d cycles", m_count, sb.size(), limit);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_w      = '0;
    rst_n     = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || out_last !== 1'b0) begin
      bad++; $display("FAIL reset_valid_last: got %b%b want 00", out_valid, out_last);
    end
    total++;
    if (fifo_count !== 3'd0 || overflow !== 1'b0 || out_index !== 2'd0) begin
      bad++; $display("FAIL reset_state: got cnt=%0d ovf=%b idx=%0d want 0 0 0", fifo_count, overflow, out_index);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1;
    push_word(make_word(64'h10, 64'h20));
    drain(8);
  endtask

  task automatic test_backpressure();
    do_reset();
    push_word(make_word(rand64(), rand64()));
    repeat (5) tick();
    total++;
    if (out_valid !== 1'b1 || out_index !== 2'd0) begin
      bad++; $display("FAIL backpressure_hold: got valid=%b idx=%0d want 1 0", out_valid, out_index);
    end
    drain(8);
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) push_word(make_word(rand64(), rand64()));
    total++;
    if (fifo_count !== 3'd4 || overflow !== 1'b1) begin
      bad++; $display("FAIL fill_overflow: got cnt=%0d ovf=%b want 4 1", fifo_count, overflow);
    end
    drain(40);
  endtask

  task automatic test_full_simul();
    do_reset();
    for (int i = 0; i < 4; i++) push_word(make_word(rand64(), rand64()));
    out_ready = 1'b1;
    repeat (3) tick();
    total++;
    if (out_index !== 2'd3 || fifo_count !== 3'd4) begin
      bad++; $display("FAIL full_setup: got idx=%0d cnt=%0d want 3 4", out_index, fifo_count);
    end
    push_word(make_word(rand64(), rand64()));
    total++;
    if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
      bad++; $display("FAIL full_push_pop: got cnt=%0d ovf=%b want 4 0", fifo_count, overflow);
    end
    drain(40);
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1;
    max_cnt   = 0;
    for (int i = 0; i < 10; i++) begin
      push_word(make_word(rand64(), rand64()));
      repeat (3) tick();
    end
    drain(16);
    total++;
    if (max_cnt > 2) begin
      bad++; $display("FAIL wrap_max_count: got %0d want <=2", max_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_word(make_word(rand64(), rand64()));
    push_word(make_word(rand64(), rand64()));
    out_ready = 1'b1;
    repeat (2) tick();
    out_ready = 1'b0;
    total++;
    if (out_index !== 2'd2 || fifo_count !== 3'd2) begin
      bad++; $display("FAIL mid_setup: got idx=%0d cnt=%0d want 2 2", out_index, fifo_count);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || fifo_count !== 3'd0 || overflow !== 1'b0 || out_index !== 2'd0) begin
      bad++; $display("FAIL mid_reset: got valid=%b cnt=%0d ovf=%b idx=%0d want 0 0 0 0", out_valid, fifo_count, overflow, out_index);
    end
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    push_word(make_word(rand64(), rand64()));
    drain(8);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    max_cnt = 0;
    test_reset();
    test_single();
    test_backpressure();
    test_fill_overflow();
    test_full_simul();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
